// File: rtl/core_pipe_pkg.sv
// ============================================================================
// core_pipe_pkg : shared IF/ID constants, field positions and stage states
// Rev 1.0
// ============================================================================
`default_nettype none

package core_pipe_pkg;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int          RS1_LSB = 15;
  localparam int          RS1_MSB = 19;
  localparam int          RS2_LSB = 20;
  localparam int          RS2_MSB = 24;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
// load_use_detect : flags a decode instruction that reads a load's rd
// Rev 1.0
// ============================================================================
`default_nettype none

module load_use_detect
  import core_pipe_pkg::*;
(
  input  logic        valid,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rd,
  input  logic [31:0] instr,
  output logic        hz
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = (idex_rd == instr[RS1_MSB:RS1_LSB]);
  assign w_rs2_hit = (idex_rd == instr[RS2_MSB:RS2_LSB]);
  assign hz        = valid & idex_memread & (idex_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);

endmodule

`default_nettype wire

// File: rtl/ifid_hazard_stage.sv
// ============================================================================
// ifid_hazard_stage : IF/ID register with load-use stall and branch squash
// Rev 1.0
// ============================================================================
`default_nettype none

module ifid_hazard_stage
  import core_pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      PC_In,
  input  logic [31:0]      Instruction_In,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_rd,
  input  logic             Branch_Taken,
  output logic [63:0]      PC_Out,
  output logic [31:0]      Instruction_Out,
  output logic             Valid_Out,
  output logic             PC_Write,
  output logic             IDEX_Bubble,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  localparam logic [2:0] c_flush_rem_init = 3'(FLUSH_CYCLES - 1);

  generate
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
      $error("ifid_hazard_stage: FLUSH_CYCLES must be in 1..7");
    end
  endgenerate

  state_t     r_state;
  logic [2:0] r_flush_rem;
  logic       w_hz;
  logic       w_stall_sat;
  logic       w_flush_sat;

  load_use_detect u_load_use_detect (
    .valid        (Valid_Out),
    .idex_memread (IDEX_MemRead),
    .idex_rd      (IDEX_rd),
    .instr        (Instruction_Out),
    .hz           (w_hz)
  );

  assign w_stall_sat = &Stall_Count;
  assign w_flush_sat = &Flush_Count;

  // PC is frozen while later squash slots drain so the branch target survives.
  always_comb begin
    PC_Write    = 1'b0;
    IDEX_Bubble = 1'b1;
    if (reset) begin
      if (Branch_Taken) begin
        PC_Write    = 1'b1;
        IDEX_Bubble = 1'b1;
      end else if (r_state == FLUSH) begin
        PC_Write    = 1'b0;
        IDEX_Bubble = 1'b0;
      end else if (w_hz) begin
        PC_Write    = 1'b0;
        IDEX_Bubble = 1'b1;
      end else begin
        PC_Write    = 1'b1;
        IDEX_Bubble = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= RUN;
      r_flush_rem     <= 3'd0;
      PC_Out          <= 64'd0;
      Instruction_Out <= NOP;
      Valid_Out       <= 1'b0;
      Stall_Count     <= '0;
      Flush_Count     <= '0;
    end else if (Branch_Taken) begin
      PC_Out          <= PC_In;
      Instruction_Out <= NOP;
      Valid_Out       <= 1'b0;
      if (!w_flush_sat) Flush_Count <= Flush_Count + 1'b1;
      if (FLUSH_CYCLES > 1) begin
        r_state     <= FLUSH;
        r_flush_rem <= c_flush_rem_init;
      end else begin
        r_state     <= RUN;
        r_flush_rem <= 3'd0;
      end
    end else if (r_state == FLUSH) begin
      PC_Out          <= PC_In;
      Instruction_Out <= NOP;
      Valid_Out       <= 1'b0;
      if (!w_flush_sat) Flush_Count <= Flush_Count + 1'b1;
      r_flush_rem     <= r_flush_rem - 3'd1;
      if (r_flush_rem == 3'd1) r_state <= RUN;
    end else if (w_hz) begin
      if (!w_stall_sat) Stall_Count <= Stall_Count + 1'b1;
      r_state <= STALL;
    end else begin
      PC_Out          <= PC_In;
      Instruction_Out <= Instruction_In;
      Valid_Out       <= 1'b1;
      r_state         <= RUN;
    end
  end

endmodule

`default_nettype wire
